// File: rtl/piece_spawner_pkg.sv
// piece_spawner_pkg: shared types and constants for the spawner
// type encoding, state encoding, shape offset ROM, LFSR seed/taps
package piece_spawner_pkg;

  typedef enum logic [2:0] {
    T_I, T_O, T_T, T_S, T_Z, T_J, T_L
  } piece_e;

  typedef enum logic [2:0] {
    S_FILL, S_IDLE, S_SELECT, S_CHECK,
    S_WRITE, S_DONE, S_OVER
  } state_e;

  localparam int N_TYPES = 7;
  localparam int N_CELLS = 4;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // taps 16,14,13,11 as bit mask in shift-right form
  localparam logic [15:0] LFSR_TAPS = 16'h002D;

  // row offsets, indexed [type][cell]
  localparam int ROW_ROM [N_TYPES][N_CELLS] = '{
    '{0, 0, 0, 0},
    '{0, 0, 1, 1},
    '{0, 0, 0, 1},
    '{0, 0, 1, 1},
    '{0, 0, 1, 1},
    '{0, 0, 0, 1},
    '{0, 0, 0, 1}
  };

  // column offsets relative to the spawn column
  localparam int COL_ROM [N_TYPES][N_CELLS] = '{
    '{-1, 0, 1,  2},
    '{ 0, 1, 0,  1},
    '{-1, 0, 1,  0},
    '{ 0, 1, -1, 0},
    '{-1, 0, 0,  1},
    '{-1, 0, 1,  1},
    '{-1, 0, 1, -1}
  };

  function automatic logic [15:0] lfsr_next(
    input logic [15:0] l
  );
    return {^(l & LFSR_TAPS), l[15:1]};
  endfunction

  // 7 is not a valid type and folds onto I
  function automatic logic [2:0] lfsr_type(
    input logic [2:0] l
  );
    return (l == 3'd7) ? 3'(T_I) : l;
  endfunction

endpackage

// File: rtl/piece_queue.sv
// piece_queue: DEPTH-deep FIFO of piece types, head always visible
// ports: clk, rst (async low), i_push, i_pop, i_din, o_head
module piece_queue #(
  parameter int DEPTH = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_push,
  input  logic       i_pop,
  input  logic [2:0] i_din,
  output logic [2:0] o_head
);

  localparam int CW = $clog2(DEPTH + 1);

  logic [DEPTH*3-1:0] r_q;
  logic [DEPTH*3-1:0] w_q;
  logic [CW-1:0]      r_cnt;
  logic [CW-1:0]      w_cnt;

  // pop shifts toward slot 0, push lands after the last valid slot
  always_comb begin
    w_q   = r_q;
    w_cnt = r_cnt;
    if (i_pop && r_cnt != '0) begin
      w_q   = w_q >> 3;
      w_cnt = w_cnt - CW'(1);
    end
    if (i_push && w_cnt != CW'(DEPTH)) begin
      for (int i = 0; i < DEPTH; i++)
        if (i == int'(w_cnt))
          w_q[i*3 +: 3] = i_din;
      w_cnt = w_cnt + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_q   <= '0;
      r_cnt <= '0;
    end else begin
      r_q   <= w_q;
      r_cnt <= w_cnt;
    end
  end

  assign o_head = r_q[2:0];

endmodule

// File: rtl/piece_spawner.sv
// piece_spawner: picks a random piece, checks the spawn area, writes it
// ports: board RAM (re/we/addr/data/rdata), en, seed load, status
module piece_spawner
  import piece_spawner_pkg::*;
#(
  parameter int BOARD_W   = 10,
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 8,
  parameter int CELLS     = 4,
  parameter int SPAWN_COL = 4,
  parameter int PREVIEW   = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    seed_load,
  input  logic [15:0]             seed,
  input  logic [DATA_W-1:0]       rdata,
  output logic                    re,
  output logic                    we,
  output logic [ADDR_W-1:0]       addr,
  output logic [DATA_W-1:0]       data,
  output logic [CELLS*ADDR_W-1:0] cell_addr,
  output logic [2:0]              piece_type,
  output logic [2:0]              next_type,
  output logic                    placed,
  output logic                    game_over
);

  localparam int KMAX = (CELLS > PREVIEW) ? CELLS : PREVIEW;
  localparam int KW   = $clog2(KMAX + 2);

  state_e                  r_state;
  logic [15:0]             r_lfsr;
  logic [KW-1:0]           r_k;
  logic                    r_hit;
  logic                    r_re;
  logic                    r_we;
  logic [ADDR_W-1:0]       r_addr;
  logic [DATA_W-1:0]       r_data;
  logic [CELLS*ADDR_W-1:0] r_cell_addr;
  logic [2:0]              r_piece_type;
  logic                    r_placed;
  logic                    r_game_over;

  logic                    w_push;
  logic                    w_pop;
  logic [2:0]              w_gen;
  logic [2:0]              w_head;
  logic [CELLS*ADDR_W-1:0] w_cells;

  function automatic logic [ADDR_W-1:0] spawn_addr(
    input logic [2:0] t,
    input int         k
  );
    int ti;
    int ki;
    int a;
    ti = (t < 3'd7) ? int'(t) : 0;
    ki = k % N_CELLS;
    a  = ROW_ROM[ti][ki] * BOARD_W
       + SPAWN_COL + COL_ROM[ti][ki];
    return a[ADDR_W-1:0];
  endfunction

  function automatic logic [ADDR_W-1:0] cell_at(
    input logic [CELLS*ADDR_W-1:0] v,
    input logic [KW-1:0]           k
  );
    return v[int'(k)*ADDR_W +: ADDR_W];
  endfunction

  assign w_push = (r_state == S_FILL) ||
                  (r_state == S_SELECT);
  assign w_pop  = (r_state == S_SELECT);
  assign w_gen  = lfsr_type(r_lfsr[2:0]);

  piece_queue #(
    .DEPTH(PREVIEW)
  ) u_queue (
    .clk   (clk),
    .rst   (rst),
    .i_push(w_push),
    .i_pop (w_pop),
    .i_din (w_gen),
    .o_head(w_head)
  );

  // addresses of the piece about to be selected
  always_comb begin
    w_cells = '0;
    for (int k = 0; k < CELLS; k++)
      w_cells[k*ADDR_W +: ADDR_W] = spawn_addr(w_head, k);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_FILL;
      r_lfsr       <= LFSR_SEED;
      r_k          <= '0;
      r_hit        <= 1'b0;
      r_re         <= 1'b0;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_data       <= '0;
      r_cell_addr  <= '0;
      r_piece_type <= '0;
      r_placed     <= 1'b0;
      r_game_over  <= 1'b0;
    end else begin
      unique case (r_state)
        S_FILL: begin
          r_lfsr <= lfsr_next(r_lfsr);
          r_k    <= r_k + KW'(1);
          if (r_k == KW'(PREVIEW - 1)) begin
            r_k     <= '0;
            r_state <= S_IDLE;
          end
        end
        S_IDLE: begin
          if (seed_load)
            r_lfsr <= (seed == '0) ? LFSR_SEED : seed;
          if (en)
            r_state <= S_SELECT;
        end
        S_SELECT: begin
          r_lfsr       <= lfsr_next(r_lfsr);
          r_piece_type <= w_head;
          r_cell_addr  <= w_cells;
          r_re         <= 1'b1;
          r_addr       <= w_cells[ADDR_W-1:0];
          r_k          <= '0;
          r_hit        <= 1'b0;
          r_state      <= S_CHECK;
        end
        S_CHECK: begin
          // rdata in cycle k answers the read of cycle k-1
          if (r_k != '0)
            r_hit <= r_hit | (rdata != '0);
          if (r_k == KW'(CELLS)) begin
            r_k <= '0;
            if (r_hit || rdata != '0) begin
              r_game_over <= 1'b1;
              r_state     <= S_OVER;
            end else begin
              r_we    <= 1'b1;
              r_addr  <= cell_at(r_cell_addr, '0);
              r_data  <= DATA_W'(r_piece_type)
                       + DATA_W'(1);
              r_state <= S_WRITE;
            end
          end else begin
            r_k <= r_k + KW'(1);
            if (int'(r_k) + 1 < CELLS) begin
              r_addr <= cell_at(r_cell_addr,
                                r_k + KW'(1));
            end else begin
              r_re   <= 1'b0;
              r_addr <= '0;
            end
          end
        end
        S_WRITE: begin
          if (int'(r_k) + 1 < CELLS) begin
            r_k    <= r_k + KW'(1);
            r_addr <= cell_at(r_cell_addr,
                              r_k + KW'(1));
          end else begin
            r_k      <= '0;
            r_we     <= 1'b0;
            r_addr   <= '0;
            r_data   <= '0;
            r_placed <= 1'b1;
            r_state  <= S_DONE;
          end
        end
        S_DONE: begin
          if (!en) begin
            r_placed <= 1'b0;
            r_state  <= S_IDLE;
          end
        end
        S_OVER: begin
          r_game_over <= 1'b1;
        end
        default: r_state <= S_FILL;
      endcase
    end
  end

  assign re         = r_re;
  assign we         = r_we;
  assign addr       = r_addr;
  assign data       = r_data;
  assign cell_addr  = r_cell_addr;
  assign piece_type = r_piece_type;
  assign next_type  = w_head;
  assign placed     = r_placed;
  assign game_over  = r_game_over;

endmodule

// File: tb/tb_piece_spawner.sv
// tb_piece_spawner: scoreboard bench for piece_spawner
// expectations queued at stimulus time, popped by a negedge monitor
module tb_piece_spawner;

  localparam int AW = 8;
  localparam int DW = 8;
  localparam int NC = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           en = 1'b0;
  logic           seed_load = 1'b0;
  logic [15:0]    seed = '0;
  logic [DW-1:0]  rdata = '0;
  logic           re;
  logic           we;
  logic [AW-1:0]  addr;
  logic [DW-1:0]  data;
  logic [NC*AW-1:0] cell_addr;
  logic [2:0]     piece_type;
  logic [2:0]     next_type;
  logic           placed;
  logic           game_over;

  piece_spawner dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .seed_load (seed_load),
    .seed      (seed),
    .rdata     (rdata),
    .re        (re),
    .we        (we),
    .addr      (addr),
    .data      (data),
    .cell_addr (cell_addr),
    .piece_type(piece_type),
    .next_type (next_type),
    .placed    (placed),
    .game_over (game_over)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  typedef struct {
    logic [2:0]       t;
    logic [NC*AW-1:0] c;
  } pl_t;

  logic [AW-1:0] rq[$];
  wr_t           wq[$];
  pl_t           pq[$];
  logic [2:0]    mq[$];
  logic [15:0]   m_lfsr;

  int  vecs = 0;
  int  errs = 0;
  bit  mon_en = 1'b0;
  logic placed_d = 1'b0;
  wr_t m_w;
  pl_t m_p;

  // board RAM stand-in: empty except an optional blocked cell
  bit            blk_en = 1'b0;
  logic [AW-1:0] blk_addr = '0;

  always @(posedge clk)
    rdata <= (re && blk_en && addr == blk_addr) ?
             8'h03 : 8'h00;

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  // hand-computed cell addresses, board 10 wide, spawn col 4
  function automatic logic [NC*AW-1:0] exp_cells(
    input logic [2:0] t
  );
    case (t)
      3'd0: return {8'd6,  8'd5,  8'd4, 8'd3};
      3'd1: return {8'd15, 8'd14, 8'd5, 8'd4};
      3'd2: return {8'd14, 8'd5,  8'd4, 8'd3};
      3'd3: return {8'd14, 8'd13, 8'd5, 8'd4};
      3'd4: return {8'd15, 8'd14, 8'd4, 8'd3};
      3'd5: return {8'd15, 8'd5,  8'd4, 8'd3};
      3'd6: return {8'd13, 8'd5,  8'd4, 8'd3};
      default: return '0;
    endcase
  endfunction

  task automatic m_gen(output logic [2:0] t);
    logic fb;
    t = (m_lfsr[2:0] == 3'd7) ? 3'd0 : m_lfsr[2:0];
    fb = m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5];
    m_lfsr = {fb, m_lfsr[15:1]};
  endtask

  task automatic m_reset();
    logic [2:0] t;
    m_lfsr = 16'hACE1;
    mq.delete();
    repeat (2) begin
      m_gen(t);
      mq.push_back(t);
    end
  endtask

  task automatic expect_spawn(output logic [2:0] t,
                              input bit writes);
    logic [2:0]       nt;
    logic [NC*AW-1:0] c;
    t = mq.pop_front();
    m_gen(nt);
    mq.push_back(nt);
    c = exp_cells(t);
    for (int k = 0; k < NC; k++) begin
      rq.push_back(c[k*AW +: AW]);
      if (writes)
        wq.push_back('{a: c[k*AW +: AW],
                       d: DW'(t) + 8'd1});
    end
    if (writes)
      pq.push_back('{t: t, c: c});
  endtask

  // one spawn from IDLE; en dropped at drop_at, seed pulse at sl_at
  task automatic spawn(input int drop_at,
                       input int sl_at,
                       input logic [15:0] sl_seed);
    logic [2:0] t;
    int n;
    bit got;
    chk("next_type_pre", next_type, mq[0]);
    expect_spawn(t, 1'b1);
    en = 1'b1;
    n = 0;
    got = 1'b0;
    while (!got && n < 40) begin
      @(negedge clk);
      n++;
      if (n == drop_at) en = 1'b0;
      seed_load = (n == sl_at);
      seed = sl_seed;
      if (placed) got = 1'b1;
    end
    seed_load = 1'b0;
    chk("place_latency", n, 11);
    if (en) begin
      @(negedge clk);
      chk("placed_hold", placed, 1);
      en = 1'b0;
    end
    @(negedge clk);
    chk("placed_drop", placed, 0);
    chk("no_game_over", game_over, 0);
  endtask

  always @(negedge clk) begin
    placed_d <= placed;
    if (rst && mon_en) begin
      if (re || we)
        chk("re_we_excl", re & we, 0);
      if (re) begin
        if (rq.size() == 0) begin
          vecs++;
          errs++;
          $display("FAIL unexp_read: addr %0d, none due",
                   addr);
        end else begin
          chk("read_addr", addr, rq.pop_front());
        end
      end
      if (we) begin
        if (wq.size() == 0) begin
          vecs++;
          errs++;
          $display("FAIL unexp_write: addr %0d, none due",
                   addr);
        end else begin
          m_w = wq.pop_front();
          chk("write_addr", addr, m_w.a);
          chk("write_data", data, m_w.d);
        end
      end
      if (placed && !placed_d) begin
        if (pq.size() == 0) begin
          vecs++;
          errs++;
          $display("FAIL unexp_placed: type %0d, none due",
                   piece_type);
        end else begin
          m_p = pq.pop_front();
          chk("placed_type", piece_type, m_p.t);
          chk("placed_cells", cell_addr, m_p.c);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [2:0] t;
    logic [2:0] prev;
    int n;
    bit got;

    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_re", re, 0);
    chk("rst_we", we, 0);
    chk("rst_placed", placed, 0);
    chk("rst_over", game_over, 0);
    chk("rst_addr", addr, 0);
    chk("rst_data", data, 0);
    chk("rst_cells", cell_addr, 0);
    chk("rst_type", piece_type, 0);
    chk("rst_queue", next_type, 0);

    rst = 1'b1;
    m_reset();
    repeat (3) @(negedge clk);
    chk("fill_head_O", next_type, 1);
    mon_en = 1'b1;

    // first spawn: O at 4,5,14,15 with data 2
    spawn(0, -1, 16'h0);
    chk("first_type_O", piece_type, 1);
    chk("first_cells", cell_addr,
        {8'd15, 8'd14, 8'd5, 8'd4});

    // zero seed in IDLE reloads ACE1
    seed = 16'h0;
    seed_load = 1'b1;
    @(negedge clk);
    seed_load = 1'b0;
    m_lfsr = 16'hACE1;
    spawn(0, -1, 16'h0);
    spawn(0, -1, 16'h0);
    chk("seeded_head", next_type, 1);

    // seed pulse during WRITE cycle 0 is ignored
    spawn(0, 7, 16'hBEEF);

    // en dropped after 3 cycles still completes
    spawn(3, -1, 16'h0);

    for (int i = 0; i < 100; i++) begin
      prev = next_type;
      spawn((i % 4 == 1) ? 3 : 0, -1, 16'h0);
      chk("type_range", piece_type < 3'd7, 1);
      chk("type_eq_prev_next", piece_type, prev);
    end
    chk("rq_drained", rq.size(), 0);
    chk("wq_drained", wq.size(), 0);

    // reset in WRITE cycle 2 aborts at once
    mon_en = 1'b0;
    en = 1'b1;
    repeat (9) @(negedge clk);
    chk("we_mid_write", we, 1);
    #2 rst = 1'b0;
    #1;
    chk("we_async_clr", we, 0);
    chk("type_async_clr", piece_type, 0);
    chk("cells_async_clr", cell_addr, 0);
    en = 1'b0;
    repeat (2) @(negedge clk);
    rq.delete();
    wq.delete();
    pq.delete();
    m_reset();
    expect_spawn(t, 1'b1);
    mon_en = 1'b1;
    en = 1'b1;
    rst = 1'b1;
    n = 0;
    got = 1'b0;
    while (!got && n < 40) begin
      @(negedge clk);
      n++;
      if (placed) got = 1'b1;
    end
    chk("post_rst_latency", n, 13);
    en = 1'b0;
    @(negedge clk);
    chk("post_rst_type", piece_type, 1);

    // collision on the cell-2 read
    mon_en = 1'b0;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rq.delete();
    wq.delete();
    pq.delete();
    m_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    blk_en = 1'b1;
    blk_addr = 8'd14;
    mon_en = 1'b1;
    expect_spawn(t, 1'b0);
    en = 1'b1;
    n = 0;
    got = 1'b0;
    while (!got && n < 40) begin
      @(negedge clk);
      n++;
      if (game_over) got = 1'b1;
    end
    chk("over_latency", n, 7);
    for (int i = 0; i < 8; i++) begin
      en = i[0];
      @(negedge clk);
      chk("over_sticky", game_over, 1);
      chk("over_no_we", we, 0);
      chk("over_no_re", re, 0);
      chk("over_no_placed", placed, 0);
    end
    chk("over_reads_done", rq.size(), 0);
    en = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("over_rst_clr", game_over, 0);
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==",
             vecs, errs);
    $finish;
  end

endmodule
